// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver with a 2-flop input synchroniser, mid-bit
// sampling state machine and a small show-ahead receive FIFO presented as a
// valid/ready stream. Frame errors and FIFO overflows are reported as 1-cycle pulses.
module uart_rx_deser #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 4
) (
  input  logic                             clk_sys_i,
  input  logic                             rst_sys_i,
  input  logic                             uart_rx_i,
  output logic [7:0]                       rx_data_o,
  output logic                             rx_valid_o,
  input  logic                             rx_ready_i,
  output logic [$clog2(FifoDepth+1)-1:0]   rx_count_o,
  output logic                             rx_busy_o,
  output logic                             rx_frame_err_o,
  output logic                             rx_overflow_o
);
  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam int PtrW       = $clog2(FifoDepth);
  localparam int CountW     = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0]   BitLast   = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]   HalfLast  = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FifoDepth);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI
  } state_e;

  logic            sync1_q;
  logic            rx_s_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            busy_q;
  logic            frame_err_q;

  logic            bit_end;
  logic            push;

  logic [7:0]        mem_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [CountW-1:0] count_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              pop;
  logic              full;
  logic              wr_en;

  // Two-flop synchroniser; idles high so a reset never looks like a start bit.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  assign bit_end = (cnt_q == BitLast);
  // A good stop bit writes the assembled byte into the FIFO on this same edge.
  assign push    = (state_q == S_STOP) && bit_end && rx_s_q;

  // Frame state machine: start-bit validation, mid-bit sampling, error recovery.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q     <= S_WAIT_HI;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_WAIT_HI: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data shift register, LSB first; datapath only, so no reset.
  always_ff @(posedge clk_sys_i) begin
    if (state_q == S_DATA && bit_end) shift_q[idx_q] <= rx_s_q;
  end

  assign rx_valid_o = (count_q != '0);
  assign full       = (count_q == CountFull);
  assign pop        = rx_valid_o && rx_ready_i;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign wr_en      = push && (!full || pop);
  assign overflow_d = push && full && !pop;

  // Occupancy next state from the write/pop combination.
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + CountW'(1);
    else if (!wr_en && pop) count_d = count_q - CountW'(1);
  end

  // FIFO control: pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful behind the valid count.
  always_ff @(posedge clk_sys_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  // Head byte is forced to zero while empty so reset presents all-zero outputs.
  assign rx_data_o      = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_count_o     = count_q;
  assign rx_busy_o      = busy_q;
  assign rx_frame_err_o = frame_err_q;
  assign rx_overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed frames into uart_rx_deser, checked every cycle
// against a queue-based FIFO model fed by frame timing computed from the bit rate,
// plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_uart_rx_deser;
  localparam int CPB   = 434;
  localparam int DEPTH = 4;
  // Edges from driving the start bit to the stop-bit sample: 2 synchroniser
  // edges, 1 edge to leave IDLE, half a bit to mid-start, then 9 full bits.
  localparam int LAT   = 3 + CPB / 2 + 9 * CPB;
  localparam int FRAME = 10 * CPB;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       line = 1'b1;
  logic       rdy  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       rx_busy;
  logic       rx_ferr;
  logic       rx_ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       ok;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  logic       rst_prev = 1'b1;
  logic       rdy_prev = 1'b0;

  uart_rx_deser dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst),
    .uart_rx_i      (line),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rdy),
    .rx_count_o     (rx_count),
    .rx_busy_o      (rx_busy),
    .rx_frame_err_o (rx_ferr),
    .rx_overflow_o  (rx_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, pushes/errors at computed frame times.
  always @(negedge clk) begin
    logic        do_pop;
    logic        do_push;
    logic        ovf;
    logic        ferr;
    logic        fullm;
    logic [7:0]  pb;
    logic [13:0] exp_p;
    logic [13:0] act_p;
    ev_t         ev;
    do_pop  = 1'b0;
    do_push = 1'b0;
    ovf     = 1'b0;
    ferr    = 1'b0;
    pb      = 8'h00;
    if (rst_prev) begin
      mq.delete();
      evq.delete();
    end else begin
      do_pop = (mq.size() != 0) && rdy_prev;
      if (evq.size() != 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.ok) begin
          do_push = 1'b1;
          pb      = ev.data;
        end else begin
          ferr = 1'b1;
        end
      end
      fullm = (mq.size() == DEPTH);
      ovf   = do_push && fullm && !do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push && !ovf) mq.push_back(pb);
    end
    exp_p = {(mq.size() != 0), 3'(mq.size()), (mq.size() != 0) ? mq[0] : 8'h00, ferr, ovf};
    act_p = {rx_valid, rx_count, ((mq.size() != 0) || rst_prev) ? rx_data : 8'h00,
             rx_ferr, rx_ovf};
    check($sformatf("cycle%0d", cyc), int'(act_p), int'(exp_p));
    rdy_prev = rdy;
    rst_prev = rst;
  end

  // Record accepted bytes and error pulses for the literal checks.
  always @(negedge clk) begin
    if (!rst && rx_valid && rdy) popped.push_back(rx_data);
    if (rx_ferr) ferr_cnt++;
    if (rx_ovf)  ovf_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame (or its first nclk cycles), optionally scheduling the
  // model event and opening ready for exactly the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nclk,
                            input bit sched, input bit pop_at_stop);
    logic [9:0] bits;
    int         t0;
    bits = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    t0   = cyc;
    line = bits[0];
    if (sched) evq.push_back('{t0 + LAT, b, stop});
    for (int j = 1; j < nclk; j++) begin
      @(posedge clk);
      #1;
      if (j % CPB == 0 && j / CPB < 10) line = bits[j / CPB];
      if (pop_at_stop && j == LAT - 1) rdy = 1'b1;
      if (pop_at_stop && j == LAT)     rdy = 1'b0;
    end
  endtask

  task automatic pop_all(input string name);
    rdy = 1'b1;
    for (int i = 0; i < 20 && rx_valid; i++) wait_cycles(1);
    rdy = 1'b0;
    check({name, "_empty"}, int'(rx_valid), 0);
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    line = 1'b1;
    rdy  = 1'b0;
    wait_cycles(3);
    check("rst_busy",  int'(rx_busy),  0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_count", int'(rx_count), 0);
    check("rst_data",  int'(rx_data),  0);
    check("rst_ferr",  int'(rx_ferr),  0);
    check("rst_ovf",   int'(rx_ovf),   0);
    rst = 1'b0;
    wait_cycles(5);

    // 1: single 0x55, consumer always ready
    rdy = 1'b1;
    popped.delete();
    fork
      send_frame(8'h55, 1'b1, FRAME, 1, 0);
      begin
        wait_cycles(2000);
        check("t1_busy_mid", int'(rx_busy), 1);
      end
    join
    wait_cycles(100);
    check("t1_busy_end", int'(rx_busy), 0);
    check("t1_n",        popped.size(), 1);
    check("t1_d",        int'(popped[0]), 8'h55);
    check("t1_ferr",     ferr_cnt, 0);
    rdy = 1'b0;

    // 2: back-to-back 0xA5, 0x3C held in the FIFO
    popped.delete();
    send_frame(8'hA5, 1'b1, FRAME, 1, 0);
    send_frame(8'h3C, 1'b1, FRAME, 1, 0);
    wait_cycles(50);
    check("t2_count", int'(rx_count), 2);
    check("t2_head",  int'(rx_data), 8'hA5);
    pop_all("t2");
    check("t2_n",  popped.size(), 2);
    check("t2_d0", int'(popped[0]), 8'hA5);
    check("t2_d1", int'(popped[1]), 8'h3C);

    // 3: 100-cycle low glitch is rejected
    line = 1'b0;
    wait_cycles(50);
    check("t3_busy_glitch", int'(rx_busy), 1);
    wait_cycles(50);
    line = 1'b1;
    wait_cycles(300);
    check("t3_busy_end", int'(rx_busy), 0);
    check("t3_count",    int'(rx_count), 0);
    check("t3_ferr",     ferr_cnt, 0);

    // 4: bad stop bit, held-low line, then recovery with 0x42
    send_frame(8'h81, 1'b0, FRAME, 1, 0);
    wait_cycles(2000);
    check("t4_ferr",      ferr_cnt, 1);
    check("t4_count",     int'(rx_count), 0);
    check("t4_busy_hold", int'(rx_busy), 1);
    line = 1'b1;
    wait_cycles(10);
    check("t4_busy_rel", int'(rx_busy), 0);
    popped.delete();
    rdy = 1'b1;
    send_frame(8'h42, 1'b1, FRAME, 1, 0);
    wait_cycles(100);
    rdy = 1'b0;
    check("t4_n", popped.size(), 1);
    check("t4_d", int'(popped[0]), 8'h42);

    // 5: fill past depth, then a push coinciding with a pop on a full FIFO
    popped.delete();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, FRAME, 1, 0);
    wait_cycles(50);
    check("t5_count", int'(rx_count), 4);
    check("t5_ovf",   ovf_cnt, 1);
    send_frame(8'h06, 1'b1, FRAME, 1, 1);
    wait_cycles(20);
    check("t5_count_swap", int'(rx_count), 4);
    check("t5_ovf_swap",   ovf_cnt, 1);
    pop_all("t5");
    check("t5_n", popped.size(), 5);
    for (int k = 0; k < 4; k++) check($sformatf("t5_d%0d", k), int'(popped[k]), k + 1);
    check("t5_d4", int'(popped[4]), 8'h06);

    // 6: reset while receiving data bit 3, then a clean 0x7E
    popped.delete();
    send_frame(8'h7E, 1'b1, 3 + CPB / 2 + 3 * CPB + 200, 0, 0);
    rst  = 1'b1;
    line = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("t6_busy_rst",  int'(rx_busy), 0);
    check("t6_count_rst", int'(rx_count), 0);
    rdy = 1'b1;
    send_frame(8'h7E, 1'b1, FRAME, 1, 0);
    wait_cycles(100);
    rdy = 1'b0;
    check("t6_n",    popped.size(), 1);
    check("t6_d",    int'(popped[0]), 8'h7E);
    check("t6_ferr", ferr_cnt, 1);
    check("t6_ovf",  ovf_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
